// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Includes the owner encoding, parameter defaults and the starvation-counter width helper.
package riscv_mem_pkg;

    localparam int DEF_AW         = 32;
    localparam int DEF_DW         = 32;
    localparam int DEF_STARVE_MAX = 4;
    localparam int DEF_CNT_W      = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    // The counter must be able to hold STARVE_MAX itself.
    function automatic int starve_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant select: data wins unless fetch has waited STARVE_MAX data grants.
// No latency; the loser is backpressured through its gnt staying low.
module mem_arb_grant
    import riscv_mem_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int SW         = starve_w(STARVE_MAX)
) (
    input  logic          if_req,
    input  logic          d_req,
    input  logic [SW-1:0] starve_cnt,
    output logic          if_gnt,
    output logic          d_gnt
);

    logic w_if_forced;

    assign w_if_forced = (starve_cnt == SW'(STARVE_MAX));

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (d_req && !(if_req && w_if_forced)) begin
            d_gnt = 1'b1;
        end else if (if_req) begin
            if_gnt = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync memory between fetch and data ports; gnt->ready latency is 1 cycle.
// The loser of a conflict sees gnt=0 / stall=1 and must hold its request until granted.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             if_req,
    input  logic [AW-1:0]    if_addr,
    output logic             if_gnt,
    output logic             if_ready,
    output logic [DW-1:0]    if_rdata,
    output logic             if_stall,

    input  logic             d_req,
    input  logic             d_we,
    input  logic [AW-1:0]    d_addr,
    input  logic [DW-1:0]    d_wdata,
    output logic             d_gnt,
    output logic             d_ready,
    output logic [DW-1:0]    d_rdata,
    output logic             d_stall,

    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,

    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int SW = starve_w(STARVE_MAX);

    logic             w_if_req;
    logic             w_d_req;
    logic             w_if_gnt;
    logic             w_d_gnt;
    owner_t           w_pend_nxt;
    owner_t           r_pend;
    logic [SW-1:0]    r_starve_cnt;
    logic [CNT_W-1:0] r_conflict_cnt;

    // Requests are masked during reset so no grant, stall or memory command escapes.
    assign w_if_req = if_req & ~rst;
    assign w_d_req  = d_req  & ~rst;

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX),
        .SW         (SW)
    ) u_grant (
        .if_req     (w_if_req),
        .d_req      (w_d_req),
        .starve_cnt (r_starve_cnt),
        .if_gnt     (w_if_gnt),
        .d_gnt      (w_d_gnt)
    );

    assign if_gnt   = w_if_gnt;
    assign d_gnt    = w_d_gnt;
    assign if_stall = w_if_req & ~w_if_gnt;
    assign d_stall  = w_d_req  & ~w_d_gnt;
    assign mem_en   = w_if_gnt | w_d_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (w_if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    always_comb begin
        w_pend_nxt = OWN_NONE;
        if (w_d_gnt) begin
            w_pend_nxt = OWN_D;
        end else if (w_if_gnt) begin
            w_pend_nxt = OWN_I;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend         <= OWN_NONE;
            r_starve_cnt   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_pend <= w_pend_nxt;

            if (!w_if_req || w_if_gnt) begin
                r_starve_cnt <= '0;
            end else if (w_d_gnt && (r_starve_cnt < SW'(STARVE_MAX))) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end

            if (if_req && d_req) begin
                r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
            end
        end
    end

    assign if_ready     = (r_pend == OWN_I);
    assign d_ready      = (r_pend == OWN_D);
    assign if_rdata     = mem_rdata;
    assign d_rdata      = mem_rdata;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural memory and reference model.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] conflict_cnt;

    mem_port_arbiter #(
        .AW(32), .DW(32), .STARVE_MAX(STARVE_MAX), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_ready(if_ready),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory environment, driven only by the DUT's mem_* command.
    logic [31:0] env_mem [logic [31:0]];
    function automatic logic [31:0] env_rd(input logic [31:0] a);
        if (env_mem.exists(a)) return env_mem[a];
        return init_word(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) env_mem[mem_addr] = mem_wdata;
            else                 mem_rdata = env_rd(mem_addr);
        end
    end

    // Reference model state: expected memory contents, starvation run, conflict count, last owner.
    logic [31:0] ref_mem [logic [31:0]];
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    int          m_starve = 0;
    logic [31:0] m_conflict = 32'd0;
    int          m_prev = 0;
    logic [31:0] if_q [$];
    logic [32:0] d_q [$];

    task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [31:0] da, input logic [31:0] dwd,
                       output logic gi, output logic gd);
        logic        exp_i, exp_d;
        logic [71:0] act, exp;
        @(negedge clk);
        rst = 1'b0; if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        #1;
        exp_d = dr && !(ir && (m_starve == STARVE_MAX));
        exp_i = ir && !exp_d;
        act = {if_gnt, d_gnt, if_stall, d_stall, if_ready, d_ready, mem_en, mem_we, mem_addr, mem_wdata};
        exp = {exp_i, exp_d, ir & ~exp_i, dr & ~exp_d, m_prev == 1, m_prev == 2, exp_i | exp_d,
               exp_d & dwe, exp_d ? da : (exp_i ? ia : 32'd0), exp_d ? dwd : 32'd0};
        check("grant_vec", 128'(act), 128'(exp));
        check("conflict_cnt", 128'(conflict_cnt), 128'(m_conflict));
        if (exp_i) if_q.push_back(ref_rd(ia));
        if (exp_d) begin
            if (dwe) begin
                ref_mem[da] = dwd;
                d_q.push_back({1'b0, 32'd0});
            end else begin
                d_q.push_back({1'b1, ref_rd(da)});
            end
        end
        if (!ir || exp_i)                         m_starve = 0;
        else if (exp_d && m_starve < STARVE_MAX) m_starve++;
        if (ir && dr) m_conflict = m_conflict + 32'd1;
        m_prev = exp_d ? 2 : (exp_i ? 1 : 0);
        gi = if_gnt;
        gd = d_gnt;
    endtask

    task automatic rcyc(input logic ir, input logic dr, input logic dwe,
                        input logic [31:0] da, input logic [31:0] dwd);
        logic [69:0] act;
        @(negedge clk);
        rst = 1'b1; if_req = ir; if_addr = 32'h40; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        #1;
        act = {if_gnt, d_gnt, if_stall, d_stall, mem_en, mem_we, mem_addr, mem_wdata};
        check("reset_outputs", 128'(act), 128'(0));
        m_starve = 0; m_conflict = 32'd0; m_prev = 0;
    endtask

    // Monitor: pops the expected response whenever the DUT presents a ready.
    initial begin
        logic [31:0] ei;
        logic [32:0] ed;
        forever begin
            @(posedge clk);
            #1;
            if (if_ready === 1'b1) begin
                if (if_q.size() == 0) check("if_ready_spurious", 128'(if_ready), 128'(0));
                else begin
                    ei = if_q.pop_front();
                    check("if_rdata", 128'(if_rdata), 128'(ei));
                end
            end
            if (d_ready === 1'b1) begin
                if (d_q.size() == 0) check("d_ready_spurious", 128'(d_ready), 128'(0));
                else begin
                    ed = d_q.pop_front();
                    if (ed[32]) check("d_rdata", 128'(d_rdata), 128'(ed[31:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        gi, gd;
        logic        ir, dr, dwe;
        logic [31:0] ia, da, dwd;
        string       seq;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;
        env_mem[32'h40] = 32'h0050_0093;
        ref_mem[32'h40] = 32'h0050_0093;

        // Reset with both requests high, then idle: no ready, counters cleared.
        rcyc(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
        rcyc(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
        repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);

        // Lone fetch.
        cyc(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);

        // Back-to-back write then read of the same word.
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, gi, gd);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, gi, gd);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);

        // Single contention cycle, then fetch alone.
        cyc(1'b1, 32'h44, 1'b1, 1'b0, 32'h200, 32'h0, gi, gd);
        cyc(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);

        // Starvation: both requests held ten cycles.
        seq = "";
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 32'h48, 1'b1, 1'b0, 32'h204, 32'h0, gi, gd);
            seq = {seq, gd ? "D" : (gi ? "I" : "-")};
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
        n_cmp++;
        if (seq != "DDDDIDDDDI") begin
            n_err++;
            $display("FAIL starve_seq: got %s expected DDDDIDDDDI", seq);
        end

        // Reset hitting a write: the write must not land and no ready may follow.
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
        rcyc(1'b0, 1'b1, 1'b1, 32'h80, 32'h1234_5678);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
        check("mem80_kept", 128'(env_rd(32'h80)), 128'(init_word(32'h80)));
        cyc(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);

        // Random traffic; a stalled requester holds its request unchanged.
        ir = 1'b0; dr = 1'b0; ia = '0; da = '0; dwe = 1'b0; dwd = '0; gi = 1'b0; gd = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!(ir && !gi)) begin
                ir = ($urandom_range(0, 3) != 0);
                ia = 32'($urandom_range(0, 15)) << 2;
            end
            if (!(dr && !gd)) begin
                dr  = ($urandom_range(0, 1) != 0);
                dwe = ($urandom_range(0, 2) == 0);
                da  = 32'($urandom_range(0, 15)) << 2;
                dwd = $urandom;
            end
            cyc(ir, ia, dr, dwe, da, dwd, gi, gd);
        end
        repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
        check("if_q_left", 128'(if_q.size()), 128'(0));
        check("d_q_left", 128'(d_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbiter that shares one single-port synchronous unified memory between the pipelined core's instruction-fetch port and its data (MEM-stage) port. It selects one access per cycle and gives data accesses priority, because they belong to the older instruction. A starvation counter bounds how long fetch can be locked out. Stall outputs feed the hazard unit, and a conflict counter supports performance debug.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_MAX, 4, consecutive data grants while fetch waits before fetch is forced
CNT_W, 32, width of conflict_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch request; if_addr must be stable while if_req=1 and if_gnt=0
if_addr  in  AW  fetch address
if_gnt  out  1  fetch accepted this cycle (combinational)
if_ready  out  1  fetch data valid (one cycle after if_gnt)
if_rdata  out  DW  fetch data
if_stall  out  1  if_req & ~if_gnt
d_req  in  1  data request
d_we  in  1  1 = write, 0 = read
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_gnt  out  1  data accepted this cycle
d_ready  out  1  data access complete (one cycle after d_gnt)
d_rdata  out  DW  read data
d_stall  out  1  d_req & ~d_gnt
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data; valid in the cycle after a read command
conflict_cnt  out  CNT_W  count of cycles with if_req & d_req

Behaviour:
- Memory contract: command sampled at the clock edge ending cycle t. Read data appears on mem_rdata in t+1. Writes commit at that edge.
- Grant logic is combinational from current requests and state. At most one gnt per cycle.
  - Only d_req: d_gnt.
  - Only if_req: if_gnt.
  - Both requests and starve_cnt < STARVE_MAX: d_gnt.
  - Both requests and starve_cnt == STARVE_MAX: if_gnt.
- mem_en = if_gnt | d_gnt. mem_addr, mem_we and mem_wdata are muxed from the granted port. When nothing is granted: mem_we=0, mem_addr=0, mem_wdata=0.
- Handshake is pipelined. After X_gnt in cycle t the requester may present its next request in t+1, so back-to-back grants to the same port are legal.
- Registered owner: pend ∈ {NONE, I, D} captures the granted port each cycle.
  - if_ready = (pend==I); d_ready = (pend==D).
  - if_rdata = d_rdata = mem_rdata (pass-through).
  - d_rdata is meaningful only for reads. After a write, d_ready still pulses with latency 1.
- starve_cnt (0..STARVE_MAX):
  - Increments on d_gnt while if_req=1.
  - Clears on if_gnt or when if_req=0.
  - Never exceeds STARVE_MAX.
- conflict_cnt increments in every cycle with if_req & d_req, regardless of grant. Wraps at 2^CNT_W.
- Reset (rst=1 at an edge):
  - pend=NONE, starve_cnt=0, conflict_cnt=0.
  - While rst=1: gnts=0, mem_en=0, mem_we=0, stalls=0.
  - No ready pulse in the first cycle after rst deasserts. An access in flight when reset hits is dropped and produces no ready.
- Simultaneous events: if_ready for the previous access and d_gnt for a new one may coincide. Ready and gnt are independent.
- Latency: fixed 1 cycle from gnt to ready for both ports.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - Owner encoding OWN_NONE=2'd0, OWN_I=2'd1, OWN_D=2'd2.
  - Default STARVE_MAX.
  - AW/DW defaults.
- One natural sub-module, mem_arb_grant: combinational priority and starvation grant selection (inputs if_req, d_req, starve_cnt; outputs if_gnt, d_gnt).
- Counters, pend register and muxes stay in mem_port_arbiter.

Test Plan:
1. Reset: rst=1 for 2 cycles with if_req=1, d_req=1 -> mem_en=0, gnts=0, stalls=0. After release, no ready pulse until a new gnt. conflict_cnt=0 after release.
2. Lone fetch: mem[0x40]=0x00500093, if_req with if_addr=0x40 -> if_gnt and mem_addr=0x40 in cycle t; if_ready=1 and if_rdata=0x00500093 in t+1.
3. Back-to-back data:
   - Cycle t: write 0x100=0xDEADBEEF.
   - Cycle t+1: read 0x100.
   - Expect: d_gnt in both cycles; d_ready in t+1 and t+2; d_rdata=0xDEADBEEF in t+2.
4. Contention: if_req and d_req (0x200) both high one cycle, starve_cnt=0 -> d_gnt=1, if_stall=1, conflict_cnt +1. if_gnt follows in the next cycle if d_req drops.
5. Starvation: STARVE_MAX=4, if_req and d_req held 10 cycles -> grant sequence D,D,D,D,I,D,D,D,D,I; conflict_cnt=10.
6. Reset mid-op: rst=1 in a cycle where d_req=1, d_we=1, addr 0x80, data 0x12345678 -> mem_we=0, mem[0x80] unchanged, no d_ready in the following cycle.
